// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, reset PC and FSM state encoding for the ONC-16 PC/fetch unit.
// The optional link-register feature is selected by the PC_LINK_EN macro in pc_fetch_unit.
package pc_fetch_unit_pkg;

  localparam int PF_PC_W   = 16;
  localparam int PF_INST_W = 16;
  localparam int PF_ST_W   = 2;

  localparam logic [PF_PC_W-1:0] PF_RESET_PC = 16'h0000;

  typedef enum logic [PF_ST_W-1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_ISSUE = 2'd2,
    PF_HALT  = 2'd3
  } pf_state_e;

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selector: branch target when taken, otherwise pc+1 wrapping mod 2^PC_W.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = PF_PC_W
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_is_br,
  input  logic [PC_W-1:0] i_br_target,
  output logic [PC_W-1:0] o_pc_next
);

  logic [PC_W-1:0] w_pc_inc;

  assign w_pc_inc  = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign o_pc_next = i_is_br ? i_br_target : w_pc_inc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer (IDLE/FETCH/ISSUE/HALT) for the ONC-16 core.
// Define PC_LINK_EN to add the branch-and-link port i_link and the o_link_addr register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = PF_PC_W,
  parameter int              INST_W   = PF_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PF_RESET_PC
) (
  input  logic              i_clock,
  input  logic              i_n_rst,
  input  logic              i_run,
  input  logic              i_halt_req,
  input  logic              i_is_br,
  input  logic [PC_W-1:0]   i_br_target,
  input  logic              i_stall,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_halted
`ifdef PC_LINK_EN
  ,
  input  logic              i_link,
  output logic [PC_W-1:0]   o_link_addr
`endif
);

  pf_state_e         r_state;
  pf_state_e         w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_inst_pc;
  logic              r_halted;
  logic              w_consume;

  // An instruction leaves ISSUE only on a non-stalled cycle; branch/halt inputs matter only then.
  assign w_consume = (r_state == PF_ISSUE) && !i_stall;

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .i_pc        (r_pc),
    .i_is_br     (i_is_br),
    .i_br_target (i_br_target),
    .o_pc_next   (w_pc_next)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_n_rst) begin
      r_state <= PF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PF_IDLE:  w_state_nxt = i_run ? PF_FETCH : PF_IDLE;
      PF_FETCH: w_state_nxt = i_imem_ack ? PF_ISSUE : PF_FETCH;
      PF_ISSUE: begin
        if (w_consume) begin
          w_state_nxt = i_halt_req ? PF_HALT : PF_FETCH;
        end else begin
          w_state_nxt = PF_ISSUE;
        end
      end
      PF_HALT:  w_state_nxt = PF_HALT;
      default:  w_state_nxt = PF_IDLE;
    endcase
  end

  // Output decode: only the memory request is combinational from state
  always_comb begin
    o_imem_req = 1'b0;
    case (r_state)
      PF_FETCH: o_imem_req = 1'b1;
      PF_IDLE,
      PF_ISSUE,
      PF_HALT:  o_imem_req = 1'b0;
      default:  o_imem_req = 1'b0;
    endcase
  end

  // PC, instruction latch and halt flag
  always_ff @(posedge i_clock) begin
    if (!i_n_rst) begin
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= {INST_W{1'b0}};
      r_inst_pc    <= {PC_W{1'b0}};
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        PF_FETCH: begin
          if (i_imem_ack) begin
            r_inst       <= i_imem_rdata;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
          end
        end
        PF_ISSUE: begin
          if (w_consume) begin
            r_pc         <= w_pc_next;
            r_inst_valid <= 1'b0;
            r_halted     <= i_halt_req;
          end
        end
        default: begin
          r_inst_valid <= r_inst_valid;
        end
      endcase
    end
  end

`ifdef PC_LINK_EN
  logic [PC_W-1:0] r_link_addr;
  logic [PC_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Link register captures the return address of a taken branch-and-link
  always_ff @(posedge i_clock) begin
    if (!i_n_rst) begin
      r_link_addr <= {PC_W{1'b0}};
    end else if (w_consume && i_is_br && i_link) begin
      r_link_addr <= w_pc_inc;
    end else begin
      r_link_addr <= r_link_addr;
    end
  end

  assign o_link_addr = r_link_addr;
`endif

  assign o_imem_addr  = r_pc;
  assign o_pc         = r_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, link sequence (PC_LINK_EN)
// and a randomized run against a flag-based behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        n_rst, run, halt_req, is_br, stall, ack, link;
  logic [15:0] br_target, rdata;
  logic        imem_req, inst_valid, halted;
  logic [15:0] imem_addr, inst, inst_pc, pc;
`ifdef PC_LINK_EN
  logic [15:0] link_addr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .i_clock      (clk),
    .i_n_rst      (n_rst),
    .i_run        (run),
    .i_halt_req   (halt_req),
    .i_is_br      (is_br),
    .i_br_target  (br_target),
    .i_stall      (stall),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .o_pc         (pc),
    .o_halted     (halted)
`ifdef PC_LINK_EN
    ,
    .i_link       (link),
    .o_link_addr  (link_addr)
`endif
  );

  typedef struct {
    logic        n_rst, run, halt_req, is_br;
    logic [15:0] br_target;
    logic        stall, ack;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_inst, e_ipc, e_pc;
    logic        e_halted;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic n, logic r, logic h, logic b, logic [15:0] t, logic s,
                              logic a, logic [15:0] d, logic er, logic [15:0] ea, logic ev,
                              logic [15:0] ei, logic [15:0] ep, logic [15:0] epc, logic eh);
    vec_t v;
    v.n_rst = n; v.run = r; v.halt_req = h; v.is_br = b; v.br_target = t;
    v.stall = s; v.ack = a; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = ep;
    v.e_pc = epc; v.e_halted = eh;
    return v;
  endfunction

  task automatic drive(logic n, logic r, logic h, logic b, logic [15:0] t, logic s,
                       logic a, logic [15:0] d, logic l);
    n_rst = n; run = r; halt_req = h; is_br = b; br_target = t;
    stall = s; ack = a; rdata = d; link = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string name, logic er, logic [15:0] ea, logic ev, logic [15:0] ei,
                            logic [15:0] ep, logic [15:0] epc, logic eh);
    logic [81:0] got, exp;
    got = {imem_req, imem_addr, inst_valid, inst, inst_pc, pc, halted};
    exp = {er, ea, ev, ei, ep, epc, eh};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h valid=%b inst=%h ipc=%h pc=%h halted=%b, want req=%b addr=%h valid=%b inst=%h ipc=%h pc=%h halted=%b",
               name, imem_req, imem_addr, inst_valid, inst, inst_pc, pc, halted,
               er, ea, ev, ei, ep, epc, eh);
    end
  endtask

  // Behavioural model: phase flags rather than a state code
  logic        m_waiting, m_holding, m_halted;
  logic [15:0] m_pc, m_inst, m_ipc, m_link;

  task automatic model_step();
    if (!n_rst) begin
      m_waiting = 1'b0; m_holding = 1'b0; m_halted = 1'b0;
      m_pc = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000; m_link = 16'h0000;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_holding) begin
      if (!stall) begin
        if (is_br && link) m_link = 16'((32'(m_pc) + 32'd1) % 32'd65536);
        m_pc      = is_br ? br_target : 16'((32'(m_pc) + 32'd1) % 32'd65536);
        m_holding = 1'b0;
        if (halt_req) m_halted = 1'b1;
        else m_waiting = 1'b1;
      end
    end else if (m_waiting) begin
      if (ack) begin
        m_inst = rdata; m_ipc = m_pc; m_holding = 1'b1; m_waiting = 1'b0;
      end
    end else if (run) begin
      m_waiting = 1'b1;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

    //                n  run h  br tgt       st ack rdata     req addr     v  inst      ipc       pc        hlt
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h1234,  0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0ABC, 1, 0, 16'h0000,  0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0ABC, 1, 0, 16'h0000,  0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0ABC, 1, 1, 16'h7777,  0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0ABC, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h1234, 16'h0000, 16'h0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h5678,  0, 16'h0001, 1, 16'h5678, 16'h0001, 16'h0001, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0ABC, 0, 0, 16'h0000,  1, 16'h0ABC, 0, 16'h5678, 16'h0001, 16'h0ABC, 0));
    tbl.push_back(mk(1, 0, 1, 1, 16'h0123, 0, 0, 16'h0000,  1, 16'h0ABC, 0, 16'h5678, 16'h0001, 16'h0ABC, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h9ABC,  0, 16'h0ABC, 1, 16'h9ABC, 16'h0ABC, 16'h0ABC, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'hFFFF, 0, 0, 16'h0000,  1, 16'hFFFF, 0, 16'h9ABC, 16'h0ABC, 16'hFFFF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0011,  0, 16'hFFFF, 1, 16'h0011, 16'hFFFF, 16'hFFFF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h4444, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0011, 16'hFFFF, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'hAAAA,  0, 16'h0000, 1, 16'hAAAA, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0001, 0, 16'hAAAA, 16'h0000, 16'h0001, 1));
    tbl.push_back(mk(1, 1, 0, 1, 16'h0200, 0, 1, 16'hBBBB,  0, 16'h0001, 0, 16'hAAAA, 16'h0000, 16'h0001, 1));
    tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 1, 16'hCCCC,  0, 16'h0001, 0, 16'hAAAA, 16'h0000, 16'h0001, 1));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'hDEAD,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'hBEEF,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].n_rst, tbl[i].run, tbl[i].halt_req, tbl[i].is_br, tbl[i].br_target,
            tbl[i].stall, tbl[i].ack, tbl[i].rdata, 1'b0);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                 tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_pc, tbl[i].e_halted);
    end

`ifdef PC_LINK_EN
    // Branch to 0x0010, then branch-and-link from there: return address 0x0011
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0); tick();
    checks++;
    if (link_addr !== 16'h0000) begin
      errors++; $display("FAIL link_reset: got %h want 0000", link_addr);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1111, 1'b0); tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2222, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0, 1'b1); tick();
    checks++;
    if (link_addr !== 16'h0000) begin
      errors++; $display("FAIL link_stall_hold: got %h want 0000", link_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 1'b1); tick();
    checks++;
    if (link_addr !== 16'h0011 || pc !== 16'h0100) begin
      errors++; $display("FAIL link_capture: got link=%h pc=%h want link=0011 pc=0100", link_addr, pc);
    end
`endif

    // Randomized run against the behavioural model
    for (int c = 0; c < 3000; c++) begin
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0),
            16'($urandom),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1),
            16'($urandom),
            ($urandom_range(0, 1) == 1));
      model_step();
      tick();
      check_outs($sformatf("rand%0d", c), m_waiting, m_pc, m_holding, m_inst, m_ipc, m_pc,
                 m_halted);
`ifdef PC_LINK_EN
      checks++;
      if (link_addr !== m_link) begin
        errors++; $display("FAIL rand_link%0d: got %h want %h", c, link_addr, m_link);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
